// File: rtl/cpu_test_sequencer_pkg.sv
// rtl/cpu_test_sequencer_pkg.sv - shared constants and helpers for the CPU test sequencer
`timescale 1ns/1ps
package cpu_test_sequencer_pkg;

  // Instruction address width of the unit-test CPUs
  localparam int TEST_I_ADDR_WIDTH = 8;

  // Sequencer FSM encoding
  localparam logic [2:0] SEQ_IDLE  = 3'd0;
  localparam logic [2:0] SEQ_RST   = 3'd1;
  localparam logic [2:0] SEQ_RUN   = 3'd2;
  localparam logic [2:0] SEQ_CHECK = 3'd3;
  localparam logic [2:0] SEQ_DONE  = 3'd4;

  // Width of an index over n items, never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_test_sequencer_halt_detector.sv
// rtl/cpu_test_sequencer_halt_detector.sv - flags a program as halted once its PC stops moving
`timescale 1ns/1ps
module cpu_test_sequencer_halt_detector #(
  parameter int PC_WIDTH    = 8,
  parameter int HALT_STABLE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  localparam int SW = $clog2(HALT_STABLE + 1);

  logic                primed;
  logic [PC_WIDTH-1:0] pc_q;
  logic [SW-1:0]       stable_cnt;

  // First enabled cycle only captures the PC; later cycles count consecutive repeats
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      primed     <= 1'b0;
      pc_q       <= '0;
      stable_cnt <= '0;
    end else if (en) begin
      pc_q <= pc;
      if (!primed) begin
        primed     <= 1'b1;
        stable_cnt <= '0;
      end else if (pc == pc_q) begin
        if (stable_cnt != SW'(HALT_STABLE))
          stable_cnt <= stable_cnt + SW'(1);
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  assign halted = primed && (stable_cnt == SW'(HALT_STABLE));

endmodule

// File: rtl/cpu_test_sequencer.sv
// rtl/cpu_test_sequencer.sv - runs a bank of CPU unit tests back to back and records verdicts
`timescale 1ns/1ps
module cpu_test_sequencer
  import cpu_test_sequencer_pkg::*;
#(
  parameter int N_TESTS        = 4,
  parameter int PC_WIDTH       = TEST_I_ADDR_WIDTH,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 35,
  parameter int HALT_STABLE    = 3,
  parameter int IDX_W          = idx_width(N_TESTS),
  parameter int FC_W           = $clog2(N_TESTS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] dut_pc,
  input  logic                dut_result,
  output logic                dut_reset,
  output logic [IDX_W-1:0]    test_idx,
  output logic                busy,
  output logic                done,
  output logic [N_TESTS-1:0]  pass_mask,
  output logic [N_TESTS-1:0]  timeout_mask,
  output logic [FC_W-1:0]     fail_count
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]       state;
  logic [RST_W-1:0] rst_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             run_halted;
  logic             halted;
  logic             timeout;

  assign timeout = (cyc_cnt == CYC_W'(TIMEOUT_CYCLES - 1));

  cpu_test_sequencer_halt_detector #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != SEQ_RUN),
    .en     (state == SEQ_RUN),
    .pc     (dut_pc),
    .halted (halted)
  );

  // Sequencer FSM: reset pulse, run until halt or timeout, score, advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEQ_IDLE;
      test_idx     <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      fail_count   <= '0;
      rst_cnt      <= '0;
      cyc_cnt      <= '0;
      run_halted   <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          if (start) begin
            state        <= SEQ_RST;
            test_idx     <= '0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            fail_count   <= '0;
            rst_cnt      <= '0;
          end
        end
        SEQ_RST: begin
          if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
            state   <= SEQ_RUN;
            cyc_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        SEQ_RUN: begin
          if (halted || timeout) begin
            state      <= SEQ_CHECK;
            run_halted <= halted;
          end else if (cyc_cnt != CYC_W'(TIMEOUT_CYCLES - 1)) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        SEQ_CHECK: begin
          if (run_halted && dut_result)
            pass_mask[test_idx] <= 1'b1;
          else if (fail_count != FC_W'(N_TESTS))
            fail_count <= fail_count + FC_W'(1);
          if (!run_halted)
            timeout_mask[test_idx] <= 1'b1;
          if (test_idx == IDX_W'(N_TESTS - 1)) begin
            state <= SEQ_DONE;
          end else begin
            state    <= SEQ_RST;
            test_idx <= test_idx + IDX_W'(1);
            rst_cnt  <= '0;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  // Status decode: the selected DUT runs only during RUN and CHECK
  always_comb begin
    busy      = (state == SEQ_RST) || (state == SEQ_RUN) || (state == SEQ_CHECK);
    done      = (state == SEQ_DONE);
    dut_reset = !((state == SEQ_RUN) || (state == SEQ_CHECK));
  end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// tb/tb_cpu_test_sequencer.sv - self-checking bench for cpu_test_sequencer
`timescale 1ns/1ps
module tb_cpu_test_sequencer;

  localparam int N   = 2;
  localparam int RC  = 2;
  localparam int TO  = 35;
  localparam int HS  = 3;
  localparam int PCW = 8;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int FW  = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [PCW-1:0] dut_pc = '0;
  logic           dut_result;
  logic           dut_reset;
  logic [IW-1:0]  test_idx;
  logic           busy;
  logic           done;
  logic [N-1:0]   pass_mask;
  logic [N-1:0]   timeout_mask;
  logic [FW-1:0]  fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Bank of unit-test CPU models: each counts PC up to its halt address, then sticks
  logic [PCW-1:0] lim [N];
  logic           res [N];

  cpu_test_sequencer #(
    .N_TESTS        (N),
    .PC_WIDTH       (PCW),
    .RESET_CYCLES   (RC),
    .TIMEOUT_CYCLES (TO),
    .HALT_STABLE    (HS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dut_pc       (dut_pc),
    .dut_result   (dut_result),
    .dut_reset    (dut_reset),
    .test_idx     (test_idx),
    .busy         (busy),
    .done         (done),
    .pass_mask    (pass_mask),
    .timeout_mask (timeout_mask),
    .fail_count   (fail_count)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (dut_reset)
      dut_pc <= '0;
    else if (dut_pc < lim[test_idx])
      dut_pc <= dut_pc + 1'b1;
  end

  assign dut_result = res[test_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // PC stays at L from RUN cycle L on; the repeat is first seen at L+1 and
  // the halt is acted on HS cycles later, unless the timeout cycle comes first.
  function automatic bit model_halts(input int l);
    return (l + 1 + HS) <= (TO - 1);
  endfunction

  function automatic int model_run_len(input int l);
    return model_halts(l) ? (l + 2 + HS) : TO;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_reset"}, dut_reset, 1);
    check({tag, "_idx"}, test_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass_mask, 0);
    check({tag, "_tmo"}, timeout_mask, 0);
    check({tag, "_fails"}, fail_count, 0);
  endtask

  task automatic run_seq(input int l0, input int l1, input bit r0, input bit r1, input bit noise);
    int           ls [N];
    bit [N-1:0]   epm;
    bit [N-1:0]   etm;
    int           efc;
    int           hi;
    int           lo;
    ls[0] = l0; ls[1] = l1;
    res[0] = r0; res[1] = r1;
    lim[0] = PCW'(l0); lim[1] = PCW'(l1);
    epm = '0; etm = '0; efc = 0;
    for (int i = 0; i < N; i++) begin
      if (model_halts(ls[i]) && res[i]) epm[i] = 1'b1;
      else efc++;
      if (!model_halts(ls[i])) etm[i] = 1'b1;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_idx", test_idx, 0);
    check("start_pass", pass_mask, 0);
    check("start_tmo", timeout_mask, 0);
    check("start_fails", fail_count, 0);
    for (int i = 0; i < N; i++) begin
      hi = 0;
      while (dut_reset && busy && hi < 20) begin
        hi++;
        @(negedge clk);
      end
      check("rst_len", hi, RC);
      check("run_idx", test_idx, i);
      lo = 0;
      while (!dut_reset && lo < 100) begin
        start = noise && (lo == 3);
        lo++;
        @(negedge clk);
      end
      start = 1'b0;
      check("run_len", lo, model_run_len(ls[i]) + 1);
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_dut_reset", dut_reset, 1);
    check("end_pass", pass_mask, epm);
    check("end_tmo", timeout_mask, etm);
    check("end_fails", fail_count, efc);
  endtask

  initial begin
    int w;
    lim[0] = '0; lim[1] = '0;
    res[0] = 1'b0; res[1] = 1'b0;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    // halts at PC 9 with result 1, then a program that never halts
    run_seq(9, 200, 1'b1, 1'b1, 1'b0);
    // immediate halt with result 0, then a short pass; start pulsed while busy
    run_seq(0, 5, 1'b0, 1'b1, 1'b1);
    // halt lands on the timeout cycle (halt wins), then one cycle too late
    run_seq(30, 31, 1'b1, 1'b1, 1'b0);

    // reset during RUN of test 1 aborts everything
    res[0] = 1'b1; res[1] = 1'b1;
    lim[0] = PCW'(2); lim[1] = PCW'(200);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    w = 0;
    while (!(test_idx == IW'(1) && !dut_reset) && w < 300) begin
      w++;
      @(negedge clk);
    end
    check("reach_test1", (w < 300), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b0;
    @(negedge clk);
    run_seq(4, 12, 1'b1, 1'b0, 1'b0);

    // randomized programs against the arithmetic model
    for (int k = 0; k < 8; k++) begin
      run_seq(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
